// File: rtl/fifo_mac_pkg.sv
// Shared definitions for the FIFO-fed multiply-accumulate engine: default
// widths, the job length width and the controller state encoding. The same
// constants size the upstream FIFOs.
package fifo_mac_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DATA_DEPTH_DEF = 16;
    localparam int ACC_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH     = 4;   // $clog2(DATA_DEPTH_DEF)
    localparam int LEN_WIDTH      = 5;   // holds 0..16

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/fifo_mac_engine_if.sv
// Bus between the MAC engine and its surroundings: job control, the two
// upstream FIFO read ports and the result handshake. The slave modport is the
// engine; the master modport is whatever drives jobs and feeds the FIFOs.
interface fifo_mac_engine_if
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
);
    localparam int AW = $clog2(DATA_DEPTH);

    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  in_empty;
    logic                  wt_empty;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] wt_data;
    logic                  in_rd_en;
    logic                  wt_rd_en;
    logic [AW-1:0]         in_rd_addr;
    logic [AW-1:0]         wt_rd_addr;
    logic [ACC_WIDTH-1:0]  acc_out;
    logic                  acc_valid;
    logic                  acc_ready;
    logic                  busy;

    modport master (
        output start, len, in_empty, wt_empty, in_data, wt_data, acc_ready,
        input  in_rd_en, wt_rd_en, in_rd_addr, wt_rd_addr, acc_out, acc_valid, busy
    );

    modport slave (
        input  start, len, in_empty, wt_empty, in_data, wt_data, acc_ready,
        output in_rd_en, wt_rd_en, in_rd_addr, wt_rd_addr, acc_out, acc_valid, busy
    );

endinterface

// File: rtl/fifo_mac_engine_mac_acc.sv
// mac_acc: signed product of two FIFO operands, sign-extended into a signed
// accumulator. Define FIFO_MAC_SAT_EN to clamp each accumulate to the signed
// accumulator range; otherwise the sum wraps modulo 2^ACC_WIDTH.
// Assumes ACC_WIDTH >= 2*DATA_WIDTH.
module mac_acc
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        product;
    logic signed [ACC_WIDTH-1:0] product_ext;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;

    assign product     = a * b;
    // Size cast of a signed value sign-extends.
    assign product_ext = ACC_WIDTH'(product);

`ifdef FIFO_MAC_SAT_EN
    logic [ACC_WIDTH:0] sum_wide;

    assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {product_ext[ACC_WIDTH-1], product_ext};

    // Clamp when the guard bit disagrees with the sign bit (signed overflow).
    always_comb begin
        // NOTE: assign a default before any condition so no path leaves acc_d unassigned, which would infer a latch.
        acc_d = sum_wide[ACC_WIDTH-1:0];
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            acc_d = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign acc_d = acc_q + product_ext;
`endif

    // Accumulator register: cleared per job, updated on each valid operand pair.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fifo_mac_engine.sv
// fifo_mac_engine: computes one signed dot product per job by reading the
// input and weight FIFOs in lock-step from a shared, persistent read pointer,
// then presents the result with a valid/ready handshake.
// Optional build macro: FIFO_MAC_SAT_EN (saturating accumulation in mac_acc).
module fifo_mac_engine
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fifo_mac_engine_if.slave       bus
);
    localparam int AW = $clog2(DATA_DEPTH);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] READ  = ST_READ;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [LEN_WIDTH-1:0] issue_cnt;
    logic [LEN_WIDTH-1:0] job_len;
    logic [AW-1:0]        rd_ptr;
    logic                 pipe_vld;
    logic                 issue;
    logic                 job_start;
    logic                 last_issue;

    // A start is only honoured from IDLE; anywhere else it is ignored.
    assign job_start  = (state == IDLE) && bus.start;
    // Both FIFOs are read together, and only when both hold data.
    assign issue      = (state == READ) && !bus.in_empty && !bus.wt_empty
                        && (issue_cnt < job_len);
    assign last_issue = issue && ((issue_cnt + LEN_WIDTH'(1)) == job_len);

    // Next-state logic for the job controller.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : READ;
            READ:    if (last_issue) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (bus.acc_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Controller state, issue counter, latched job length, shared read
    // pointer (persists across jobs) and the one-cycle FIFO data-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            job_len   <= '0;
            rd_ptr    <= '0;
            pipe_vld  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pipe_vld <= issue;
            if (job_start) begin
                issue_cnt <= '0;
                job_len   <= bus.len;
            end else if (issue) begin
                issue_cnt <= issue_cnt + LEN_WIDTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    mac_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (job_start),
        .en    (pipe_vld),
        .a     (bus.in_data),
        .b     (bus.wt_data),
        .acc   (bus.acc_out)
    );

    assign bus.in_rd_en   = issue;
    assign bus.wt_rd_en   = issue;
    assign bus.in_rd_addr = rd_ptr;
    assign bus.wt_rd_addr = rd_ptr;
    assign bus.acc_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_mac_engine.sv
// Self-checking bench for fifo_mac_engine. A driver issues directed jobs and
// pushes hand-computed results and read addresses into queues; a monitor on
// the falling edge pops and compares whenever the DUT reads or presents a
// result. Overflow expectations follow FIFO_MAC_SAT_EN.
module tb_fifo_mac_engine;

    typedef struct {
        logic signed [31:0] acc;
        int                 start_cyc;
        int                 lat;      // -1: result due no later than 2 cycles
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    logic prev_vld;

    exp_t sb_q[$];
    int   addr_q[$];

    logic signed [15:0] in_mem[16];
    logic signed [15:0] wt_mem[16];

    fifo_mac_engine_if #(.DATA_WIDTH(16), .DATA_DEPTH(16), .ACC_WIDTH(32)) bus ();

    fifo_mac_engine #(.DATA_WIDTH(16), .DATA_DEPTH(16), .ACC_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO model: registered read data.
    always @(posedge clk) begin
        if (bus.in_rd_en) bus.in_data <= in_mem[bus.in_rd_addr];
        if (bus.wt_rd_en) bus.wt_data <= wt_mem[bus.wt_rd_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int n, input int addr0, input logic signed [31:0] acc, input int lat);
        exp_t e;
        for (int i = 0; i < n; i++) addr_q.push_back((addr0 + i) % 16);
        e.acc       = acc;
        e.start_cyc = cyc;
        e.lat       = lat;
        sb_q.push_back(e);
        bus.start = 1'b1;
        bus.len   = 5'(n);
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (sb_q.size() == 0 && addr_q.size() == 0 && !bus.busy) done = 1'b1;
        end
        if (!done) fail_now({name, " timeout waiting for job completion"});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_rd_en"},   bus.in_rd_en,   0);
        check({tag, "_wt_rd_en"},   bus.wt_rd_en,   0);
        check({tag, "_acc_valid"},  bus.acc_valid,  0);
        check({tag, "_busy"},       bus.busy,       0);
        check({tag, "_acc_out"},    bus.acc_out,    0);
        check({tag, "_in_rd_addr"}, bus.in_rd_addr, 0);
    endtask

    // Monitor: read addresses, lock-step enables, result latency and value.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld <= 1'b0;
        end else begin
            prev_vld <= bus.acc_valid;
            if (bus.in_rd_en || bus.wt_rd_en) begin
                check("rd_en_addr_pair", {bus.in_rd_en, bus.in_rd_addr}, {bus.wt_rd_en, bus.wt_rd_addr});
                if (addr_q.size() == 0) fail_now($sformatf("unexpected read at addr %0d", bus.in_rd_addr));
                else check("rd_addr", bus.in_rd_addr, addr_q.pop_front());
            end
            if (bus.acc_valid) begin
                if (sb_q.size() == 0) begin
                    if (!prev_vld) fail_now("unexpected acc_valid");
                end else begin
                    if (!prev_vld) begin
                        if (sb_q[0].lat < 0) check("len0_latency_le2", (cyc - sb_q[0].start_cyc) <= 2, 1);
                        else check("latency", cyc - sb_q[0].start_cyc, sb_q[0].lat);
                    end
                    if (bus.acc_ready) begin
                        check("acc_out", $signed(bus.acc_out), sb_q[0].acc);
                        void'(sb_q.pop_front());
                    end else begin
                        check("acc_out_hold", $signed(bus.acc_out), sb_q[0].acc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.in_empty = 1'b0;
        bus.wt_empty = 1'b0;
        bus.acc_ready = 1'b1;
        bus.in_data = '0;
        bus.wt_data = '0;
        for (int i = 0; i < 16; i++) begin
            in_mem[i] = '0;
            wt_mem[i] = '0;
        end

        // Reset state.
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Basic job: in = 1..4, wt = 2 at addrs 0..3 -> 20, valid at cycle 6.
        for (int i = 0; i < 4; i++) begin
            in_mem[i] = 16'(i + 1);
            wt_mem[i] = 16'sd2;
        end
        kick(4, 0, 32'sd20, 6);
        wait_idle("basic", 40);

        // Stall: weight FIFO empty in cycles 3..5, addrs 4..7 -> -41, valid at cycle 9.
        in_mem[4] = -16'sd3; wt_mem[4] = 16'sd4;
        in_mem[5] = 16'sd5;  wt_mem[5] = -16'sd6;
        in_mem[6] = 16'sd7;  wt_mem[6] = 16'sd3;
        in_mem[7] = -16'sd2; wt_mem[7] = 16'sd10;
        kick(4, 4, -32'sd41, 9);
        step();
        step();
        bus.wt_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_rd_en", bus.in_rd_en, 0);
            check("stall_wt_rd_en", bus.wt_rd_en, 0);
            step();
        end
        bus.wt_empty = 1'b0;
        wait_idle("stall", 40);

        // Handshake: addrs 8,9 -> 100*-7 + -50*3 = -850; ready held low, start in DONE ignored.
        in_mem[8] = 16'sd100; wt_mem[8] = -16'sd7;
        in_mem[9] = -16'sd50; wt_mem[9] = 16'sd3;
        bus.acc_ready = 1'b0;
        kick(2, 8, -32'sd850, 4);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (bus.acc_valid) seen = 1'b1;
                else step();
            end
            if (!seen) fail_now("handshake timeout waiting for acc_valid");
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) begin
                bus.start = 1'b1;
                bus.len   = 5'd3;
            end
            if (i == 2) bus.start = 1'b0;
            check("hold_acc_valid", bus.acc_valid, 1);
            check("hold_busy", bus.busy, 1);
        end
        bus.acc_ready = 1'b1;
        step();
        check("post_accept_acc_valid", bus.acc_valid, 0);
        check("post_accept_busy", bus.busy, 0);
        step();
        check("start_in_done_ignored_busy", bus.busy, 0);
        wait_idle("handshake", 20);

        // len = 0: result 0 within two cycles, no reads.
        kick(0, 0, 32'sd0, -1);
        wait_idle("len0", 20);

        // Reset in READ: reads at 10,11 (9*9 each), then input FIFO empty.
        in_mem[10] = 16'sd9; wt_mem[10] = 16'sd9;
        in_mem[11] = 16'sd9; wt_mem[11] = 16'sd9;
        addr_q.push_back(10);
        addr_q.push_back(11);
        bus.start = 1'b1;
        bus.len   = 5'd4;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.in_empty = 1'b1;
        step();
        check("midjob_busy", bus.busy, 1);
        check("midjob_partial_acc", $signed(bus.acc_out), 162);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        step();
        rst_n = 1'b1;
        bus.in_empty = 1'b0;
        check("reads_consumed_before_reset", addr_q.size(), 0);
        step();

        // Wrap: pointer restarts at 0; in[i] = i-8, wt = 3.
        for (int i = 0; i < 16; i++) begin
            in_mem[i] = 16'(i - 8);
            wt_mem[i] = 16'sd3;
        end
        kick(12, 0, -32'sd90, 14);
        wait_idle("wrap_a", 60);
        kick(12, 12, -32'sd42, 14);
        wait_idle("wrap_b", 60);

        // Overflow: 16 x (0x7FFF * 0x7FFF) from addrs 8..15, 0..7.
        for (int i = 0; i < 16; i++) begin
            in_mem[i] = 16'h7FFF;
            wt_mem[i] = 16'h7FFF;
        end
`ifdef FIFO_MAC_SAT_EN
        kick(16, 8, 32'h7FFF_FFFF, 18);
`else
        kick(16, 8, 32'hFFF0_0010, 18);
`endif
        wait_idle("overflow", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_mac_engine.md
FIFO_MAC_ENGINE -- requirements
Module: fifo_mac_engine

Interface
REQ-001 Parameters, one per line, as name, default, meaning:
- DATA_WIDTH, 16, operand width of the input and weight FIFO data.
- DATA_DEPTH, 16, depth of each upstream FIFO; address width is 4.
- ACC_WIDTH, 32, signed accumulator and result width.
REQ-002 Ports, one per line, as name, direction, width, meaning:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  pulse that begins one dot-product job.
- len  in  5  job vector length, 0..16.
- in_empty  in  1  empty flag of the input FIFO.
- wt_empty  in  1  empty flag of the weight FIFO.
- in_data  in  DATA_WIDTH  input FIFO data_out, signed.
- wt_data  in  DATA_WIDTH  weight FIFO data_out, signed.
- in_rd_en  out  1  input FIFO read enable.
- wt_rd_en  out  1  weight FIFO read enable.
- in_rd_addr  out  4  input FIFO read address.
- wt_rd_addr  out  4  weight FIFO read address.
- acc_out  out  ACC_WIDTH  dot-product result, signed.
- acc_valid  out  1  result valid.
- acc_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, READ, DRAIN, DONE.
REQ-004 IDLE: start=1 SHALL move to READ, clear the accumulator and clear the issue count. If len=0, start SHALL move directly to DONE with acc_out=0.
REQ-005 IDLE: start SHALL be ignored in every other state.
REQ-006 READ: when in_empty=0, wt_empty=0 and issue count < len, in_rd_en and wt_rd_en SHALL both be asserted in the same cycle.
REQ-007 Both FIFOs SHALL always be read together; neither rd_en SHALL ever be asserted alone.
REQ-008 If either empty flag is high, both rd_en SHALL be low and the FSM SHALL stall in READ, with no timeout.
REQ-009 in_rd_addr and wt_rd_addr SHALL come from one shared 4-bit pointer.
REQ-010 The pointer SHALL increment once per issued read and wrap from 15 to 0.
REQ-011 The pointer SHALL persist across jobs; only reset clears it.
REQ-012 FIFO data is registered, so a read issued in cycle N presents valid data in cycle N+1. The block SHALL keep a 1-bit pipeline valid flag that tracks this.
REQ-013 On a cycle with the valid flag set, the accumulator SHALL update as acc <= acc + sext(in_data*wt_data), a signed 2*DATA_WIDTH product.
REQ-014 After the len-th read is issued, the FSM SHALL go to DRAIN for exactly one cycle to absorb the last product, then go to DONE.
REQ-015 DONE: acc_valid=1 and acc_out SHALL hold stable until acc_ready=1.
REQ-016 DONE with acc_ready=1 SHALL return to IDLE on the next clock, with acc_valid low.
REQ-017 Latency: for len=L with no stalls, start at cycle 0 SHALL produce acc_valid at cycle L+2.
REQ-018 busy SHALL be high in READ, DRAIN and DONE.

Reset
REQ-019 rst_n=0 SHALL force, asynchronously, the following values:
- FSM=IDLE, pointer=0, issue count=0, valid flag=0, accumulator=0.
- in_rd_en=0, wt_rd_en=0, acc_valid=0, busy=0, acc_out=0.
REQ-020 A reset asserted mid-job SHALL abandon the job with no result produced.
REQ-021 Reset release SHALL take effect on the next rising clk edge.

Configuration
REQ-022 With FIFO_MAC_SAT_EN defined, each accumulate SHALL saturate to the signed ACC_WIDTH bounds, +2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1).
REQ-023 Without FIFO_MAC_SAT_EN, accumulation SHALL wrap modulo 2^ACC_WIDTH.

Structure
REQ-024 Package fifo_mac_pkg SHALL hold the state enum typedef and default-width constants, shared with the FIFO instantiation.
REQ-025 The multiply-accumulate datapath SHALL be a sub-module mac_acc containing:
- the product,
- sign extension,
- the optional saturation,
- the accumulator register.

Verification
REQ-026 Basic job: FIFOs preloaded with in=1..4 and wt=2, len=4, start -> in_rd_addr 0..3, acc_out=20, acc_valid at cycle 6.
REQ-027 Stall: the weight FIFO is empty for 3 cycles mid-job -> no rd_en pulses during the stall, and the result is correct, delayed 3 cycles.
REQ-028 Wrap: two back-to-back jobs with len=12 -> the second job's addresses run 12..15, 0..7, and no reset occurs between jobs.
REQ-029 Overflow: 16 products of 0x7FFF*0x7FFF -> saturates to 0x7FFFFFFF with FIFO_MAC_SAT_EN, and wraps to 0xFFF00010 without it.
REQ-030 Handshake: acc_ready held low for 5 cycles -> acc_out stable, and a start pulse during DONE is ignored.
REQ-031 Edge cases:
- len=0 -> acc_valid with acc_out=0 two cycles after start, with no rd_en.
- rst_n asserted in READ -> all outputs are at their reset values immediately.
